upzero_mc: RTL and testbench
============================

Name: upzero_mc

Overview:
- Parametrised, multi-channel successor to the ADPCM zero-predictor coefficient updater (upzero).
- Holds the delayed-difference line (dlti) and zero-predictor coefficients (bli) internally for NCH independent channels, e.g. G.722 lower and higher sub-band.
- On each start it applies a sign-sign LMS update with leakage to one channel, one tap per cycle, then shifts that channel's delay line.
- Adds over the previous block: configurable tap count, widths, leak and step; per-channel clear; registered coefficient readback.

Parameters:
- NTAPS, 6: taps per channel (≥2).
- NCH, 2: independent channels (≥1).
- DW, 17: width of dlt and dlti entries, signed.
- CW, 32: bli coefficient width, signed.
- LEAK_SH, 8: leak shift L; leak factor is (2^L−1)/2^L.
- STEP, 128: LMS step magnitude (< 2^(CW−1)).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  synchronous, active-low reset.
- ap_start  in  1  start request; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse, operation complete.
- ap_idle  out  1  high in IDLE.
- ap_ready  out  1  one-cycle pulse, identical to ap_done.
- dlt  in  DW  signed quantised difference; sampled with ap_start.
- ch_sel  in  clog2(NCH) (min 1)  target channel; sampled with ap_start or clr.
- clr  in  1  in IDLE, zero all dlti/bli of ch_sel.
- rd_ch  in  clog2(NCH) (min 1)  readback channel.
- rd_tap  in  clog2(NTAPS)  readback tap.
- bli_rd  out  CW  registered bli[rd_ch][rd_tap].
- dlti_rd  out  DW  registered dlti[rd_ch][rd_tap].

Behaviour:
- Reset (ap_rst_n=0 at an edge): FSM→IDLE; all storage zeroed; bli_rd=0, dlti_rd=0.
  - ap_done=ap_ready=0; ap_idle=1 from the first cycle after reset.
  - Reset mid-operation abandons the update; no partial result is preserved, since all storage is zeroed.
- FSM states: IDLE → UPD (NTAPS cycles, index i=0..NTAPS−1) → SHF (1 cycle) → DONE (1 cycle) → IDLE.
- IDLE:
  - ap_start=1: latch dlt, ch_sel and zflag=(dlt==0); i←0; go to UPD.
  - ap_start=1 and clr=1 together: start wins, clr is dropped.
  - clr=1 alone: zero channel ch_sel at that edge; remain in IDLE.
- UPD, tap i:
  - b=bli[ch][i], d=dlti[ch][i].
  - lk=((b<<L)−b)>>>L, evaluated at CW+L bits signed, truncated to CW.
  - If zflag: bli←lk.
  - Else: p=dlt_latched*d, full signed product.
    - p<0: bli←lk−STEP.
    - p≥0, including p=0: bli←lk+STEP.
    - Result wraps modulo 2^CW; no saturation.
    - A sign-only implementation (XOR of signs plus zero detect) is permitted.
- SHF: dlti[ch][k]←dlti[ch][k−1] for k=NTAPS−1..1; dlti[ch][0]←dlt_latched. This happens in one cycle, including when dlt=0.
- DONE: ap_done=ap_ready=1 for exactly one cycle.
- Latency: start accepted at edge 0; ap_done high during cycle NTAPS+2. With ap_start held high, back-to-back operations run every NTAPS+3 cycles.
- ap_start and clr outside IDLE are ignored; they are not queued.
- Channels other than the latched ch are never modified.
- Readback: bli_rd/dlti_rd are registered from rd_ch/rd_tap at each edge, in any state.
  - During UPD/SHF the value reflects storage at that edge, which may be partially updated.
  - Out-of-range rd_tap/rd_ch returns 0.

Test Plan (NTAPS=6, NCH=2, DW=17, CW=32, L=8, STEP=128):
- Reset, then readback of all 12 entries → all 0; ap_idle=1, ap_done=0.
- ch0, dlt=5 → ap_done pulses in cycle 8 after start.
  - bli[0..5]=128.
  - dlti=[5,0,0,0,0,0].
- ch0, dlt=−3 → bli=[−1,255,255,255,255,255]; dlti=[−3,5,0,0,0,0].
- ch0, dlt=0 (leak only) → bli=[−1,254,254,254,254,254]; dlti=[0,−3,5,0,0,0].
- ch1, dlt=7 → ch1 bli all 128; ch0 unchanged.
  - Then clr with ch_sel=0 → ch0 all 0; ch1 intact.
  - clr together with ap_start → start taken, no clear.
- ap_start held high → ops every 9 cycles; start pulses mid-op ignored.
  - ap_rst_n=0 at cycle 3 of UPD → all storage 0; FSM in IDLE at the next cycle.

Source files
------------

// File: rtl/upzero_mc_if.sv
// upzero_mc_if: control, data and readback bundle for the multi-channel
// zero-predictor coefficient updater.
//
// Handshake: ap_start is a level request that the block looks at only while
// ap_idle is high. The rising edge where ap_start=1 and ap_idle=1 is the
// acceptance edge, and dlt/ch_sel are captured at that edge. ap_done and
// ap_ready then pulse high together for exactly one cycle when the result is
// in storage. A start that arrives while the block is busy is dropped, not
// queued. clr is a single-cycle command that also acts only while idle, and
// an accepted start takes priority over it.
//
// Signals:
//   ap_start, dlt, ch_sel, clr  master -> slave  operation request
//   ap_done, ap_ready, ap_idle  slave -> master  status
//   rd_ch, rd_tap               master -> slave  readback address
//   bli_rd, dlti_rd             slave -> master  registered readback data
interface upzero_mc_if #(
    parameter int NTAPS = 6,
    parameter int NCH   = 2,
    parameter int DW    = 17,
    parameter int CW    = 32
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW  = $clog2(NTAPS);

    logic           ap_start;
    logic           ap_done;
    logic           ap_idle;
    logic           ap_ready;
    logic [DW-1:0]  dlt;
    logic [CHW-1:0] ch_sel;
    logic           clr;
    logic [CHW-1:0] rd_ch;
    logic [TW-1:0]  rd_tap;
    logic [CW-1:0]  bli_rd;
    logic [DW-1:0]  dlti_rd;

    modport master (
        output ap_start, dlt, ch_sel, clr, rd_ch, rd_tap,
        input  ap_done, ap_idle, ap_ready, bli_rd, dlti_rd
    );

    modport slave (
        input  ap_start, dlt, ch_sel, clr, rd_ch, rd_tap,
        output ap_done, ap_idle, ap_ready, bli_rd, dlti_rd
    );
endinterface

// File: rtl/upzero_mc.sv
// upzero_mc: multi-channel ADPCM zero-predictor coefficient updater.
// Each channel has a delay line dlti[NTAPS] and a coefficient set bli[NTAPS],
// both stored internally. An accepted start runs a sign-sign LMS update with
// leakage over the selected channel, one tap per cycle. It then shifts the
// new dlt into that channel's delay line and pulses ap_done/ap_ready.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   synchronous active-low reset, zeroes all storage
//   bus        upzero_mc_if.slave: start/done/idle/ready, dlt, ch_sel, clr,
//              and the rd_ch/rd_tap -> bli_rd/dlti_rd readback port
//   dbg_state  current FSM state (0 IDLE, 1 UPD, 2 SHF, 3 DONE)
module upzero_mc #(
    parameter int NTAPS   = 6,
    parameter int NCH     = 2,
    parameter int DW      = 17,
    parameter int CW      = 32,
    parameter int LEAK_SH = 8,
    parameter int STEP    = 128
) (
    input  logic       ap_clk,
    input  logic       ap_rst_n,
    upzero_mc_if.slave bus,
    output logic [1:0] dbg_state
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW  = $clog2(NTAPS);
    localparam logic [CW-1:0] STEP_C   = CW'(STEP);
    localparam logic [TW-1:0] LAST_TAP = TW'(NTAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UPD  = 2'd1,
        S_SHF  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t         state_q;
    logic [TW-1:0]  idx_q;
    logic [DW-1:0]  dlt_q;
    logic [CHW-1:0] ch_q;
    logic           zflag_q;
    logic           done_q;
    logic           idle_q;

    logic [CW-1:0] bli_q  [NCH][NTAPS];
    logic [CW-1:0] bli_d  [NCH][NTAPS];
    logic [DW-1:0] dlti_q [NCH][NTAPS];
    logic [DW-1:0] dlti_d [NCH][NTAPS];

    logic [CW-1:0] bli_rd_q, bli_rd_d;
    logic [DW-1:0] dlti_rd_q, dlti_rd_d;

    // ----------------------------------------------------------------------
    // Control FSM. ap_done/ap_idle are registered. ap_done therefore rises
    // in the cycle after DONE, which is also the first IDLE cycle. Accepted
    // starts are NTAPS+3 cycles apart.
    // ----------------------------------------------------------------------
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            dlt_q   <= '0;
            ch_q    <= '0;
            zflag_q <= 1'b0;
            done_q  <= 1'b0;
            idle_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            idle_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.ap_start) begin
                        dlt_q   <= bus.dlt;
                        ch_q    <= bus.ch_sel;
                        zflag_q <= (bus.dlt == '0);
                        idx_q   <= '0;
                        state_q <= S_UPD;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                S_UPD: begin
                    if (idx_q == LAST_TAP) begin
                        state_q <= S_SHF;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_SHF: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                    idle_q  <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // ----------------------------------------------------------------------
    // Per-tap coefficient update
    // ----------------------------------------------------------------------
    logic                         ch_ok;
    logic                         sel_ok;
    logic [CW-1:0]                cur_b;
    logic [DW-1:0]                cur_d;
    logic signed [CW+LEAK_SH-1:0] b_ext;
    logic signed [CW+LEAK_SH-1:0] lk_full;
    logic [CW-1:0]                lk;
    logic                         prod_neg;
    logic [CW-1:0]                upd_b;

    always_comb begin
        ch_ok  = (int'(ch_q) < NCH);
        sel_ok = (int'(bus.ch_sel) < NCH);
        cur_b  = '0;
        cur_d  = '0;
        if (ch_ok) begin
            cur_b = bli_q[ch_q][idx_q];
            cur_d = dlti_q[ch_q][idx_q];
        end
        // b*(2^L-1)/2^L, computed with L guard bits so the left shift cannot
        // overflow before the arithmetic right shift brings it back.
        b_ext   = {{LEAK_SH{cur_b[CW-1]}}, cur_b};
        lk_full = ((b_ext <<< LEAK_SH) - b_ext) >>> LEAK_SH;
        lk      = lk_full[CW-1:0];
        // The product dlt*d is negative only when both factors are nonzero
        // and their signs differ. dlt==0 takes the zflag path instead.
        prod_neg = (dlt_q[DW-1] ^ cur_d[DW-1]) && (cur_d != '0);
        if (zflag_q) begin
            upd_b = lk;
        end else if (prod_neg) begin
            upd_b = lk - STEP_C;
        end else begin
            upd_b = lk + STEP_C;
        end
    end

    // ----------------------------------------------------------------------
    // Storage next-state: clear, tap update, delay-line shift
    // ----------------------------------------------------------------------
    always_comb begin
        bli_d  = bli_q;
        dlti_d = dlti_q;
        case (state_q)
            S_IDLE: begin
                // An accepted start takes priority, so a clear is dropped
                // in the same cycle.
                if (bus.clr && !bus.ap_start && sel_ok) begin
                    for (int t = 0; t < NTAPS; t++) begin
                        bli_d[bus.ch_sel][t]  = '0;
                        dlti_d[bus.ch_sel][t] = '0;
                    end
                end
            end
            S_UPD: begin
                if (ch_ok) begin
                    bli_d[ch_q][idx_q] = upd_b;
                end
            end
            S_SHF: begin
                if (ch_ok) begin
                    for (int k = NTAPS - 1; k > 0; k--) begin
                        dlti_d[ch_q][k] = dlti_q[ch_q][k-1];
                    end
                    dlti_d[ch_q][0] = dlt_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                for (int t = 0; t < NTAPS; t++) begin
                    bli_q[c][t]  <= '0;
                    dlti_q[c][t] <= '0;
                end
            end
        end else begin
            bli_q  <= bli_d;
            dlti_q <= dlti_d;
        end
    end

    // ----------------------------------------------------------------------
    // Registered readback. The value shows storage as it stands at the edge,
    // so during UPD/SHF it can show a partially updated channel.
    // ----------------------------------------------------------------------
    always_comb begin
        bli_rd_d  = '0;
        dlti_rd_d = '0;
        if ((int'(bus.rd_ch) < NCH) && (int'(bus.rd_tap) < NTAPS)) begin
            bli_rd_d  = bli_q[bus.rd_ch][bus.rd_tap];
            dlti_rd_d = dlti_q[bus.rd_ch][bus.rd_tap];
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            bli_rd_q  <= '0;
            dlti_rd_q <= '0;
        end else begin
            bli_rd_q  <= bli_rd_d;
            dlti_rd_q <= dlti_rd_d;
        end
    end

    assign bus.ap_done  = done_q;
    assign bus.ap_ready = done_q;
    assign bus.ap_idle  = idle_q;
    assign bus.bli_rd   = bli_rd_q;
    assign bus.dlti_rd  = dlti_rd_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_upzero_mc.sv
module tb_upzero_mc;
  localparam int NTAPS = 6;
  localparam int NCH   = 2;
  localparam int DW    = 17;
  localparam int CW    = 32;

  logic       ap_clk = 1'b0;
  logic       ap_rst_n = 1'b0;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic signed [63:0] eb [NTAPS];
  logic signed [63:0] ed [NTAPS];

  upzero_mc_if #(.NTAPS(NTAPS), .NCH(NCH), .DW(DW), .CW(CW)) bus ();

  upzero_mc #(
    .NTAPS(NTAPS), .NCH(NCH), .DW(DW), .CW(CW), .LEAK_SH(8), .STEP(128)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus.slave),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 ap_clk = ~ap_clk;

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // checking
  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic rd(input int ch, input int tap,
                    output logic signed [63:0] b, output logic signed [63:0] d);
    bus.rd_ch  = ch[0];
    bus.rd_tap = tap[2:0];
    tick();
    b = $signed(bus.bli_rd);
    d = $signed(bus.dlti_rd);
  endtask

  task automatic set_exp(input int b0, input int b1, input int d0, input int d1,
                         input int d2);
    eb[0] = b0;
    for (int t = 1; t < NTAPS; t++) eb[t] = b1;
    for (int t = 0; t < NTAPS; t++) ed[t] = 0;
    ed[0] = d0;
    ed[1] = d1;
    ed[2] = d2;
  endtask

  task automatic chk_ch(input string tag, input int ch);
    logic signed [63:0] b, d;
    for (int t = 0; t < NTAPS; t++) begin
      exp_q.push_back(eb[t]);
      exp_q.push_back(ed[t]);
    end
    for (int t = 0; t < NTAPS; t++) begin
      rd(ch, t, b, d);
      check($sformatf("%s_bli%0d", tag, t), b, $signed(exp_q.pop_front()));
      check($sformatf("%s_dlti%0d", tag, t), d, $signed(exp_q.pop_front()));
    end
  endtask

  task automatic do_op(input string tag, input int ch, input int dv, input bit with_clr);
    int k;
    bus.ch_sel   = ch[0];
    bus.dlt      = dv[DW-1:0];
    bus.ap_start = 1'b1;
    bus.clr      = with_clr;
    tick();
    bus.ap_start = 1'b0;
    bus.clr      = 1'b0;
    check({tag, "_busy_idle"}, bus.ap_idle, 0);
    for (k = 1; k <= 20; k++) begin
      tick();
      if (bus.ap_done === 1'b1) break;
    end
    check({tag, "_done_cycle"}, k, 8);
    check({tag, "_ready"}, bus.ap_ready, 1);
    check({tag, "_idle_at_done"}, bus.ap_idle, 1);
    tick();
    check({tag, "_done_low"}, bus.ap_done, 0);
  endtask

  // main sequence
  initial begin
    logic signed [63:0] b, d;
    int last, first, n, cyc;

    bus.ap_start = 1'b0;
    bus.dlt      = '0;
    bus.ch_sel   = '0;
    bus.clr      = 1'b0;
    bus.rd_ch    = '0;
    bus.rd_tap   = '0;
    ap_rst_n     = 1'b0;
    repeat (3) tick();
    ap_rst_n = 1'b1;
    check("rst_idle", bus.ap_idle, 1);
    check("rst_done", bus.ap_done, 0);
    check("rst_ready", bus.ap_ready, 0);
    check("rst_state", dbg_state, 0);
    set_exp(0, 0, 0, 0, 0);
    chk_ch("rst_ch0", 0);
    chk_ch("rst_ch1", 1);

    // ch0 dlt=5: every d is 0, so p=0 and each tap gets leak(0)+128
    do_op("op1", 0, 5, 1'b0);
    set_exp(128, 128, 5, 0, 0);
    chk_ch("op1_ch0", 0);
    rd(0, 6, b, d);
    check("oob_tap6_bli", b, 0);
    check("oob_tap6_dlti", d, 0);
    rd(0, 7, b, d);
    check("oob_tap7_bli", b, 0);

    // ch0 dlt=-3: leak(128)=127; tap0 d=5 gives p<0 -> -1, others +128 -> 255
    do_op("op2", 0, -3, 1'b0);
    set_exp(-1, 255, -3, 5, 0);
    chk_ch("op2_ch0", 0);

    // ch0 dlt=0: leak only, leak(-1)=-1 and leak(255)=254
    do_op("op3", 0, 0, 1'b0);
    set_exp(-1, 254, 0, -3, 5);
    chk_ch("op3_ch0", 0);

    // ch1 dlt=7; ch0 must keep its previous contents
    do_op("op4", 1, 7, 1'b0);
    set_exp(128, 128, 7, 0, 0);
    chk_ch("op4_ch1", 1);
    set_exp(-1, 254, 0, -3, 5);
    chk_ch("op4_ch0", 0);

    // clr of ch0 alone
    bus.ch_sel = 1'b0;
    bus.clr    = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr_idle", bus.ap_idle, 1);
    set_exp(0, 0, 0, 0, 0);
    chk_ch("clr_ch0", 0);
    set_exp(128, 128, 7, 0, 0);
    chk_ch("clr_ch1", 1);

    // clr together with start on ch1: start wins, 128 -> 127+128 = 255
    do_op("op5", 1, 7, 1'b1);
    set_exp(255, 255, 7, 7, 0);
    chk_ch("op5_ch1", 1);

    // start held high on ch0 with dlt=1; clr pulse mid-op must be ignored
    bus.ch_sel   = 1'b0;
    bus.dlt      = 17'd1;
    bus.ap_start = 1'b1;
    last  = -1;
    first = -1;
    n     = 0;
    for (cyc = 1; cyc <= 60 && n < 3; cyc++) begin
      bus.clr = (cyc == 4);
      tick();
      if (bus.ap_done === 1'b1) begin
        if (n == 0) first = cyc;
        else check($sformatf("b2b_period%0d", n), cyc - last, 9);
        last = cyc;
        n++;
      end
    end
    bus.ap_start = 1'b0;
    bus.clr      = 1'b0;
    check("b2b_first", first, 9);
    check("b2b_count", n, 3);
    tick();
    // 0 -> 128 -> 255 -> 254+128 = 382 on every tap
    set_exp(382, 382, 1, 1, 1);
    chk_ch("b2b_ch0", 0);
    set_exp(255, 255, 7, 7, 0);
    chk_ch("b2b_ch1", 1);

    // reset during cycle 3 of UPD
    bus.ch_sel   = 1'b1;
    bus.dlt      = 17'd3;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    repeat (3) tick();
    check("midrst_in_upd", dbg_state, 1);
    ap_rst_n = 1'b0;
    tick();
    ap_rst_n = 1'b1;
    check("midrst_state", dbg_state, 0);
    check("midrst_idle", bus.ap_idle, 1);
    check("midrst_done", bus.ap_done, 0);
    set_exp(0, 0, 0, 0, 0);
    chk_ch("midrst_ch0", 0);
    chk_ch("midrst_ch1", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
